fifo_ingress_arbiter: RTL and testbench

Round-robin ingress arbiter that shares one `fifo_register` write port between `NR_OF_REQ_P` valid/ready requesters. It holds a grant for bursts of up to `MAX_BURST_P` beats and never writes while the FIFO reports full. The FIFO write path has no full protection of its own, so this block is the only writer of that port. It sits directly in front of the FIFO's `ing_*` port.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/fifo_ingress_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_ingress_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and default constants for the FIFO ingress arbiter family.
//   arb_state_t : two-state arbiter FSM encoding (IDLE, GRANT).
//   *_DEF       : default parameter values used by fifo_ingress_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NR_OF_REQ_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_BURST_DEF  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. Picks the first asserted
//   request at or after rr_ptr, searching upward and wrapping at N_P-1.
//   Works for non-power-of-2 N_P; rr_ptr must be below N_P.
// Ports
//   req     in  N_P     request vector
//   rr_ptr  in  ID_W_P  index with highest priority this cycle
//   gnt     out N_P     one-hot selection (0 when no request)
//   gnt_id  out ID_W_P  index of the selection (0 when no request)
//   any_req out 1       at least one request asserted
module rr_arbiter #(
  parameter  int N_P    = 4,
  localparam int ID_W_P = (N_P > 1) ? $clog2(N_P) : 1
) (
  input  logic [N_P-1:0]    req,
  input  logic [ID_W_P-1:0] rr_ptr,
  output logic [N_P-1:0]    gnt,
  output logic [ID_W_P-1:0] gnt_id,
  output logic              any_req
);

  logic              w_found;
  logic [ID_W_P:0]   w_sum;
  logic [ID_W_P-1:0] w_idx;

  assign any_req = |req;

  // One extra bit on the sum lets rr_ptr+k exceed N_P before the explicit wrap.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_P; k++) begin
      w_sum = {1'b0, rr_ptr} + (ID_W_P+1)'(k);
      if (w_sum >= (ID_W_P+1)'(N_P)) begin
        w_sum = w_sum - (ID_W_P+1)'(N_P);
      end
      w_idx = w_sum[ID_W_P-1:0];
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_ingress_arbiter.sv
// fifo_ingress_arbiter
//   Round-robin arbiter sharing one FIFO write port among NR_OF_REQ_P
//   valid/ready requesters. A grant is held for up to MAX_BURST_P beats and
//   is released early when the granted requester drops valid. No write is
//   ever issued while fifo_full is high; this block is the only guard.
//   Build option: define FIFO_ARB_TAG_EN to place grant_id in the upper
//   ID_WIDTH_P bits of fifo_wr_data; otherwise those bits are tied to 0.
// Ports
//   clk          in  1                        clock
//   rst_n        in  1                        async active-low reset
//   req_valid    in  NR_OF_REQ_P              per-requester valid
//   req_data     in  NR_OF_REQ_P*DATA_WIDTH_P packed payloads, slice i per requester
//   req_ready    out NR_OF_REQ_P              per-requester accept (at most one high)
//   fifo_wr_en   out 1                        FIFO ing_enable
//   fifo_wr_data out DATA_WIDTH_P+ID_WIDTH_P  FIFO ing_data = {id, payload}
//   fifo_full    in  1                        FIFO ing_full
//   grant_id     out ID_WIDTH_P               current / last granted requester
//   grant_active out 1                        FSM in GRANT
module fifo_ingress_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NR_OF_REQ_P  = NR_OF_REQ_DEF,
  parameter  int DATA_WIDTH_P = DATA_WIDTH_DEF,
  parameter  int MAX_BURST_P  = MAX_BURST_DEF,
  localparam int ID_WIDTH_P   = $clog2(NR_OF_REQ_P)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NR_OF_REQ_P-1:0]              req_valid,
  input  logic [NR_OF_REQ_P*DATA_WIDTH_P-1:0] req_data,
  output logic [NR_OF_REQ_P-1:0]              req_ready,
  output logic                                fifo_wr_en,
  output logic [DATA_WIDTH_P+ID_WIDTH_P-1:0]  fifo_wr_data,
  input  logic                                fifo_full,
  output logic [ID_WIDTH_P-1:0]               grant_id,
  output logic                                grant_active
);

  localparam int CNT_W = $clog2(MAX_BURST_P + 1);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [ID_WIDTH_P-1:0]   r_rr_ptr;
  logic [ID_WIDTH_P-1:0]   r_grant_id;
  logic [NR_OF_REQ_P-1:0]  r_grant_oh;
  logic [CNT_W-1:0]        r_burst_cnt;

  logic [NR_OF_REQ_P-1:0]  w_sel_oh;
  logic [ID_WIDTH_P-1:0]   w_sel_id;
  logic                    w_any_req;
  logic                    w_gnt_valid;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_release;
  logic [ID_WIDTH_P-1:0]   w_ptr_nxt;
  logic [DATA_WIDTH_P-1:0] w_payload;
  logic [ID_WIDTH_P-1:0]   w_tag;

  rr_arbiter #(
    .N_P (NR_OF_REQ_P)
  ) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (r_rr_ptr),
    .gnt     (w_sel_oh),
    .gnt_id  (w_sel_id),
    .any_req (w_any_req)
  );

  assign grant_active = (r_state == GRANT);
  assign grant_id     = r_grant_id;

  // The stored one-hot grant avoids a variable index into req_valid, which
  // would otherwise reach past the top requester for non-power-of-2 counts.
  assign w_gnt_valid = |(req_valid & r_grant_oh);
  assign w_beat      = grant_active && w_gnt_valid && !fifo_full;
  assign w_last      = (r_burst_cnt == CNT_W'(MAX_BURST_P - 1));
  assign w_release   = grant_active && (!w_gnt_valid || (w_beat && w_last));
  assign w_ptr_nxt   = (r_grant_id == ID_WIDTH_P'(NR_OF_REQ_P - 1)) ?
                       '0 : r_grant_id + ID_WIDTH_P'(1);

  assign req_ready  = (grant_active && !fifo_full) ? r_grant_oh : '0;
  assign fifo_wr_en = w_beat;

  // AND-OR payload mux keyed by the one-hot grant.
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < NR_OF_REQ_P; i++) begin
      if (r_grant_oh[i]) begin
        w_payload = w_payload | req_data[i*DATA_WIDTH_P +: DATA_WIDTH_P];
      end
    end
  end

`ifdef FIFO_ARB_TAG_EN
  assign w_tag = r_grant_id;
`else
  assign w_tag = '0;
`endif

  assign fifo_wr_data = w_beat ? {w_tag, w_payload} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter is cleared when a grant is taken, so it may rest at MAX_BURST_P
  // after a full burst without affecting the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_grant_oh  <= '0;
      r_burst_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        r_grant_id  <= w_sel_id;
        r_grant_oh  <= w_sel_oh;
        r_burst_cnt <= '0;
      end else if (w_beat) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if (w_release) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ingress_arbiter.sv
// tb_fifo_ingress_arbiter
//   Bench for fifo_ingress_arbiter (4 requesters, 32-bit, burst 4) with a
//   second 3-requester, burst-1 instance for the non-power-of-2 wrap case.
//   Honours FIFO_ARB_TAG_EN for the expected upper data bits.
module tb_fifo_ingress_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              fifo_wr_en;
  logic [DW+IDW-1:0] fifo_wr_data;
  logic              fifo_full = 1'b0;
  logic [IDW-1:0]    grant_id;
  logic              grant_active;

  logic [2:0]  v3 = '0;
  logic [23:0] d3 = 24'h030201;
  logic [2:0]  r3;
  logic        we3;
  logic [9:0]  wd3;
  logic [1:0]  gid3;
  logic        ga3;

  int           rem [N];
  logic [DW-1:0] dat [N];
  bit           drop [N];
  bit           rnd;
  logic [31:0]  wr_log;
  int           gid_q[$];
  int           gid3_q[$];
  int           n_pass = 0;
  int           n_tot = 0;

  // behavioural reference state
  bit m_act;
  int m_gid, m_ptr, m_cnt;

  fifo_ingress_arbiter #(.NR_OF_REQ_P(N), .DATA_WIDTH_P(DW), .MAX_BURST_P(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .grant_id(grant_id), .grant_active(grant_active)
  );

  fifo_ingress_arbiter #(.NR_OF_REQ_P(3), .DATA_WIDTH_P(8), .MAX_BURST_P(1)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
    .req_ready(r3), .fifo_wr_en(we3), .fifo_wr_data(wd3),
    .fifo_full(1'b0), .grant_id(gid3), .grant_active(ga3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: one step per clock, straight from the arbitration rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_act) begin
      if (req_valid != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1;
            m_gid = (m_ptr + k) % N;
          end
        end
        m_act = 1;
        m_cnt = 0;
      end
    end else if (!req_valid[m_gid]) begin
      m_act = 0;
      m_ptr = (m_gid + 1) % N;
    end else if (!fifo_full) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_act = 0;
        m_ptr = (m_gid + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    logic          e_wr;
    logic [N-1:0]  e_rdy;
    logic [IDW-1:0] e_tag;
    logic [DW+IDW-1:0] e_data;
    e_wr  = m_act && req_valid[m_gid] && !fifo_full;
    e_rdy = (m_act && !fifo_full) ? (N'(1) << m_gid) : '0;
`ifdef FIFO_ARB_TAG_EN
    e_tag = IDW'(m_gid);
`else
    e_tag = '0;
`endif
    e_data = e_wr ? {e_tag, req_data[m_gid*DW +: DW]} : '0;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
    chk("fifo_wr_data", 64'(fifo_wr_data), 64'(e_data));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("grant_active", 64'(grant_active), 64'(m_act));
    chk("n3_gid_range", 64'(gid3 < 2'd3), 64'd1);
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = dat[i];
      req_valid[i] = (rem[i] > 0) && !drop[i];
    end
  endtask

  task automatic run(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      wr_log = {wr_log[30:0], fifo_wr_en};
      if (fifo_wr_en) gid_q.push_back(int'(grant_id));
      if (we3) gid3_q.push_back(int'(gid3));
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rem[i]--;
          dat[i] = $urandom;
        end
        if (rnd) begin
          if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 6);
          drop[i] = ($urandom_range(0, 15) == 0);
        end
      end
      if (rnd) fifo_full = ($urandom_range(0, 3) == 0);
      drive();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rnd = 0;
    fifo_full = 1'b0;
    v3 = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      drop[i] = 0;
      dat[i] = $urandom;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log = '0;
    gid_q.delete();
    gid3_q.delete();
  endtask

  initial begin
    // Single requester: 4 beats, bubble, 2 beats, release.
    do_reset();
    rem[2] = 6;
    drive();
    run(9);
    chk("single_pattern", 64'(wr_log[8:0]), 64'(9'b011110110));
    chk("single_count", 64'(gid_q.size()), 64'd6);
    foreach (gid_q[k]) chk("single_gid", 64'(gid_q[k]), 64'd2);
    chk("model_ptr_after_single", 64'(m_ptr), 64'd3);

    // All requesters valid: order 0,1,2,3,0 at 4 beats per 5 cycles.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 100;
    drive();
    run(22);
    chk("all_count", 64'(gid_q.size()), 64'd17);
    foreach (gid_q[k]) chk("all_order", 64'(gid_q[k]), 64'((k / 4) % 4));
    chk("all_tail", 64'(wr_log[4:0]), 64'(5'b11101));

    // Backpressure after beat 2.
    do_reset();
    rem[0] = 8;
    drive();
    run(3);
    chk("bp_pre", 64'(wr_log[2:0]), 64'(3'b011));
    fifo_full = 1'b1;
    run(10);
    chk("bp_hold", 64'(wr_log[9:0]), 64'd0);
    chk("bp_cnt", 64'(dut.r_burst_cnt), 64'd2);
    fifo_full = 1'b0;
    run(3);
    chk("bp_post", 64'(wr_log[2:0]), 64'(3'b110));

    // Early release with requester 3 pending.
    do_reset();
    rem[1] = 1;
    rem[3] = 2;
    drive();
    run(5);
    chk("early_pattern", 64'(wr_log[4:0]), 64'(5'b01001));
    chk("early_count", 64'(gid_q.size()), 64'd2);
    if (gid_q.size() == 2) begin
      chk("early_first", 64'(gid_q[0]), 64'd1);
      chk("early_next", 64'(gid_q[1]), 64'd3);
    end
    chk("model_gid_after_early", 64'(m_gid), 64'd3);

    // Reset during beat 3 of requester 1.
    do_reset();
    rem[1] = 8;
    drive();
    run(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_active", 64'(grant_active), 64'd0);
    rem[0] = 2;
    drive();
    gid_q.delete();
    #1;
    rst_n = 1'b1;
    run(2);
    chk("rst_regrant_count", 64'(gid_q.size()), 64'd1);
    if (gid_q.size() == 1) chk("rst_regrant_id", 64'(gid_q[0]), 64'd0);

    // Three requesters, single-beat bursts.
    do_reset();
    v3 = 3'b111;
    run(8);
    chk("n3_count", 64'(gid3_q.size()), 64'd4);
    foreach (gid3_q[k]) chk("n3_order", 64'(gid3_q[k]), 64'(k % 3));
    v3 = '0;

    // Randomised traffic against the reference.
    do_reset();
    rnd = 1;
    run(3000);
    rnd = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
